// File: rtl/lcd_read_engine.sv
// rtl/lcd_read_engine.sv - HD44780 4-bit bus reader: status/data reads with optional busy-flag polling

module lcd_read_engine #(
    parameter int SETUP_CYC  = 4,
    parameter int E_HIGH_CYC = 25,
    parameter int E_LOW_CYC  = 25,
    parameter int MAX_POLLS  = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       bus_rel,
    input  logic [3:0] lcd_d_in
);

    localparam int MAX_PH = (SETUP_CYC > E_HIGH_CYC)
                          ? ((SETUP_CYC > E_LOW_CYC) ? SETUP_CYC : E_LOW_CYC)
                          : ((E_HIGH_CYC > E_LOW_CYC) ? E_HIGH_CYC : E_LOW_CYC);
    localparam int CW = (MAX_PH > 1) ? $clog2(MAX_PH + 1) : 1;
    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        E1_HI = 3'd2,
        E1_LO = 3'd3,
        E2_HI = 3'd4,
        E2_LO = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [PW-1:0]   poll_cnt, poll_cnt_n;
    logic            rs_q, rs_n;
    logic            poll_q, poll_n;
    logic [3:0]      hi_q, hi_n;
    logic [3:0]      lo_q, lo_n;
    logic            last;

    logic            ready_n, rd_valid_n, timeout_n, lcd_rs_n, lcd_rw_n, lcd_e_n;
    logic [7:0]      rd_data_n;

    // Counter is loaded with length-1 on entry, so the phase ends on the cycle it reads zero.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            SETUP:        phase_len = CW'(SETUP_CYC - 1);
            E1_HI, E2_HI: phase_len = CW'(E_HIGH_CYC - 1);
            E1_LO, E2_LO: phase_len = CW'(E_LOW_CYC - 1);
            default:      phase_len = '0;
        endcase
    endfunction

    always_comb begin
        state_n    = state;
        rs_n       = rs_q;
        poll_n     = poll_q;
        poll_cnt_n = poll_cnt;
        hi_n       = hi_q;
        lo_n       = lo_q;
        last       = (cnt == '0);

        case (state)
            IDLE: begin
                if (req) begin
                    state_n    = SETUP;
                    rs_n       = req_rs;
                    poll_n     = req_poll & ~req_rs;
                    poll_cnt_n = '0;
                end
            end
            SETUP: if (last) state_n = E1_HI;
            E1_HI: begin
                if (last) begin
                    hi_n    = lcd_d_in;
                    state_n = E1_LO;
                end
            end
            E1_LO: if (last) state_n = E2_HI;
            E2_HI: begin
                if (last) begin
                    lo_n    = lcd_d_in;
                    state_n = E2_LO;
                end
            end
            E2_LO: begin
                if (last) begin
                    // poll_cnt holds reads completed before this one; re-strobe without a new setup.
                    if (poll_q && hi_q[3] && (poll_cnt < PW'(MAX_POLLS - 1))) begin
                        poll_cnt_n = poll_cnt + PW'(1);
                        state_n    = E1_HI;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        if (state_n != state) begin
            cnt_n = phase_len(state_n);
        end else if (last) begin
            cnt_n = '0;
        end else begin
            cnt_n = cnt - CW'(1);
        end

        // Outputs are registered from the next state so they line up with the state register.
        ready_n    = (state_n == IDLE);
        rd_valid_n = (state_n == DONE);
        lcd_e_n    = (state_n == E1_HI) || (state_n == E2_HI);
        lcd_rw_n   = (state_n != IDLE) && (state_n != DONE);
        lcd_rs_n   = lcd_rw_n & rs_n;
        rd_data_n  = rd_valid_n ? {hi_n, lo_n} : rd_data;
        timeout_n  = rd_valid_n ? (poll_n & hi_n[3]) : timeout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            poll_cnt <= '0;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            hi_q     <= 4'h0;
            lo_q     <= 4'h0;
            ready    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            timeout  <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b0;
            lcd_e    <= 1'b0;
            bus_rel  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            poll_cnt <= poll_cnt_n;
            rs_q     <= rs_n;
            poll_q   <= poll_n;
            hi_q     <= hi_n;
            lo_q     <= lo_n;
            ready    <= ready_n;
            rd_valid <= rd_valid_n;
            rd_data  <= rd_data_n;
            timeout  <= timeout_n;
            lcd_rs   <= lcd_rs_n;
            lcd_rw   <= lcd_rw_n;
            lcd_e    <= lcd_e_n;
            bus_rel  <= lcd_rw_n;
        end
    end

endmodule

// File: tb/tb_lcd_read_engine.sv
// tb/tb_lcd_read_engine.sv - randomized self-checking bench for lcd_read_engine with an LCD read-side model

module tb_lcd_read_engine;

    localparam int SETUP  = 4;
    localparam int EH     = 25;
    localparam int EL     = 25;
    localparam int MAXP   = 5;
    localparam int RD_CYC = 2 * (EH + EL);
    localparam int LAT1   = 1 + SETUP + RD_CYC;
    localparam int BUDGET = 1 + SETUP + MAXP * RD_CYC + 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       ready, rd_valid, timeout, lcd_rs, lcd_rw, lcd_e, bus_rel;
    logic [7:0] rd_data;
    logic [3:0] lcd_d_in = 4'h0;

    always #10 clk = ~clk;

    lcd_read_engine #(
        .SETUP_CYC (SETUP),
        .E_HIGH_CYC(EH),
        .E_LOW_CYC (EL),
        .MAX_POLLS (MAXP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_rs  (req_rs),
        .req_poll(req_poll),
        .ready   (ready),
        .rd_valid(rd_valid),
        .rd_data (rd_data),
        .timeout (timeout),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .bus_rel (bus_rel),
        .lcd_d_in(lcd_d_in)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // LCD model: one byte per read, high nibble on the first E pulse, low nibble on the second.
    logic [7:0] resp_q[$];
    logic [7:0] plan[$];
    logic [7:0] cur_byte = 8'h00;
    logic       nib_sel = 1'b0;
    logic       prev_e = 1'b0;
    logic       prev_rw = 1'b0;
    logic       in_setup = 1'b0;
    logic       exp_rs = 1'b0;
    int rd_idx = 0, hi_len = 0, pulses = 0, width_err = 0, rw_err = 0, rs_err = 0;
    int rw_cyc = 0, setup_cyc = 0, valid_cnt = 0, ready_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            nib_sel  = 1'b0;
            in_setup = 1'b0;
        end
        if (lcd_e && !prev_e) begin
            pulses++;
            hi_len = 1;
            if (!nib_sel) begin
                cur_byte = (rd_idx < resp_q.size()) ? resp_q[rd_idx] : 8'($urandom);
                rd_idx++;
                lcd_d_in = cur_byte[7:4];
            end else begin
                lcd_d_in = cur_byte[3:0];
            end
            nib_sel = ~nib_sel;
        end else if (lcd_e) begin
            hi_len++;
        end else begin
            lcd_d_in = 4'($urandom);
        end
        if (!lcd_e && prev_e && hi_len != EH) width_err++;
        if ((prev_e || lcd_e) && lcd_rw != prev_rw) rw_err++;
        if (bus_rel != lcd_rw) rw_err++;
        if (lcd_rw && !prev_rw) in_setup = 1'b1;
        if (lcd_e) in_setup = 1'b0;
        if (lcd_rw) begin
            rw_cyc++;
            if (in_setup) setup_cyc++;
            if (lcd_rs != exp_rs) rs_err++;
        end
        if (rd_valid) valid_cnt++;
        if (ready) ready_cnt++;
        prev_e  = lcd_e;
        prev_rw = lcd_rw;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input string tag, input logic rs, input logic poll);
        int reads, cyc;
        int p_pulses, p_rw, p_setup, p_werr, p_rwerr, p_rserr, p_valid, p_idx;
        logic [7:0] exp_d;
        logic exp_to;
        bit got;
        reads = 1;
        if (poll && !rs) begin
            while (reads < MAXP && plan[reads-1][7]) reads++;
        end
        exp_d  = plan[reads-1];
        exp_to = poll && !rs && exp_d[7];
        for (int i = 0; i < reads; i++) resp_q.push_back(plan[i]);
        exp_rs = rs;
        step();
        check({tag, " ready"}, 32'(ready), 32'(1));
        p_pulses = pulses; p_rw = rw_cyc; p_setup = setup_cyc; p_werr = width_err;
        p_rwerr = rw_err; p_rserr = rs_err; p_valid = valid_cnt; p_idx = rd_idx;
        req = 1'b1; req_rs = rs; req_poll = poll;
        cyc = 0;
        got = 0;
        while (!got && cyc < BUDGET) begin
            step();
            cyc++;
            req = 1'b0; req_rs = 1'($urandom); req_poll = 1'($urandom);
            if (rd_valid) got = 1;
        end
        req_rs = 1'b0; req_poll = 1'b0;
        check({tag, " latency"}, 32'(cyc), 32'(1 + SETUP + reads * RD_CYC));
        check({tag, " rd_data"}, 32'(rd_data), 32'(exp_d));
        check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
        check({tag, " e_pulses"}, 32'(pulses - p_pulses), 32'(2 * reads));
        check({tag, " rw_cycles"}, 32'(rw_cyc - p_rw), 32'(SETUP + reads * RD_CYC));
        check({tag, " setup_cycles"}, 32'(setup_cyc - p_setup), 32'(SETUP));
        check({tag, " reads"}, 32'(rd_idx - p_idx), 32'(reads));
        check({tag, " e_width_err"}, 32'(width_err - p_werr), 32'(0));
        check({tag, " rw_stable_err"}, 32'(rw_err - p_rwerr), 32'(0));
        check({tag, " rs_err"}, 32'(rs_err - p_rserr), 32'(0));
        step();
        check({tag, " valid_pulses"}, 32'(valid_cnt - p_valid), 32'(1));
        check({tag, " rd_data_hold"}, 32'(rd_data), 32'(exp_d));
    endtask

    initial begin
        int cyc, nv, t1, t2, p_valid, p_ready, rdy_win;
        logic [7:0] b0, b1;
        bit hit;

        // Reset
        rst = 1'b1;
        repeat (3) step();
        check("rst ready", 32'(ready), 32'(1));
        check("rst lcd_e", 32'(lcd_e), 32'(0));
        check("rst lcd_rw", 32'(lcd_rw), 32'(0));
        check("rst bus_rel", 32'(bus_rel), 32'(0));
        check("rst rd_valid", 32'(rd_valid), 32'(0));
        check("rst rd_data", 32'(rd_data), 32'(0));
        check("rst timeout", 32'(timeout), 32'(0));
        rst = 1'b0;
        step();

        plan = '{8'hA5};
        run_txn("status", 1'b0, 1'b0);

        plan = '{8'h48};
        run_txn("data", 1'b1, 1'b1);

        plan = '{8'h80 | 8'($urandom_range(0, 127)), 8'h80 | 8'($urandom_range(0, 127)),
                 8'h80 | 8'($urandom_range(0, 127)), 8'h07, 8'h80};
        run_txn("poll4", 1'b0, 1'b1);

        plan = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5};
        run_txn("poll_to", 1'b0, 1'b1);

        for (int n = 0; n < 10; n++) begin
            plan.delete();
            for (int i = 0; i < MAXP; i++)
                plan.push_back({($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 7'($urandom)});
            run_txn($sformatf("rand%0d", n), 1'($urandom), 1'($urandom));
        end

        // Abort during the second E pulse
        resp_q.push_back(8'($urandom));
        exp_rs = 1'b0;
        step();
        p_valid = valid_cnt;
        t1 = pulses;
        req = 1'b1; req_rs = 1'b0; req_poll = 1'b0;
        step();
        req = 1'b0;
        cyc = 0;
        hit = 0;
        while (!hit && cyc < BUDGET) begin
            step();
            cyc++;
            if (pulses - t1 == 2 && lcd_e) hit = 1;
        end
        check("abort reached_e2", 32'(hit), 32'(1));
        rst = 1'b1;
        step();
        check("abort lcd_e", 32'(lcd_e), 32'(0));
        check("abort lcd_rw", 32'(lcd_rw), 32'(0));
        check("abort ready", 32'(ready), 32'(1));
        rst = 1'b0;
        repeat (60) step();
        check("abort no_valid", 32'(valid_cnt - p_valid), 32'(0));
        plan = '{8'h3C};
        run_txn("after_abort", 1'b0, 1'b0);

        // req held high: back-to-back transactions with one IDLE cycle between
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        resp_q.push_back(b0);
        resp_q.push_back(b1);
        exp_rs = 1'b0;
        step();
        req = 1'b1; req_rs = 1'b0; req_poll = 1'b0;
        p_valid = valid_cnt;
        p_ready = ready_cnt;
        cyc = 0; nv = 0; t1 = 0; t2 = 0; rdy_win = 0;
        while (nv < 2 && cyc < 2 * LAT1 + 20) begin
            step();
            cyc++;
            if (rd_valid) begin
                nv++;
                if (nv == 1) begin
                    t1 = cyc;
                    check("busy rd_data0", 32'(rd_data), 32'(b0));
                end else begin
                    t2 = cyc;
                    check("busy rd_data1", 32'(rd_data), 32'(b1));
                    rdy_win = ready_cnt - p_ready;
                    req = 1'b0;
                end
            end
        end
        check("busy t1", 32'(t1), 32'(LAT1));
        check("busy t2", 32'(t2), 32'(2 * LAT1 + 1));
        check("busy idle_cycles", 32'(rdy_win), 32'(1));
        repeat (20) step();
        check("busy valid_count", 32'(valid_cnt - p_valid), 32'(2));
        check("busy end_rw", 32'(lcd_rw), 32'(0));
        check("busy end_ready", 32'(ready), 32'(1));
        check("busy rs_err", 32'(rs_err), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
